// File: rtl/mem_write_checker.sv
// Store-path self-check monitor: matches core stores in order against a loadable
// table of expected (address, data) pairs and reports pass, mismatch or timeout.
module mem_write_checker #(
   parameter int              DW         = 32,
   parameter int              AW         = 32,
   parameter int              DEPTH      = 4,
   parameter bit              IGNORE_EN  = 1'b1,
   parameter logic [AW-1:0]   IGNORE_ADR = AW'(80),
   parameter int              TIMEOUT    = 1000,
   localparam int             IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          exp_we,
   input  logic [IW-1:0] exp_idx,
   input  logic [AW-1:0] exp_adr,
   input  logic [DW-1:0] exp_data,
   input  logic [IW:0]   num_exp,
   input  logic          start,
   input  logic          clear,
   input  logic          memwrite,
   input  logic [AW-1:0] dataadr,
   input  logic [DW-1:0] writedata,
   output logic          busy,
   output logic          pass,
   output logic          fail,
   output logic [1:0]    fail_code,
   output logic [IW:0]   match_cnt,
   output logic [7:0]    ignore_cnt,
   output logic [AW-1:0] err_adr,
   output logic [DW-1:0] err_data
);

   localparam int          CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IW:0] DEPTH_L = (IW + 1)'(DEPTH);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PASS = 2'd2,
      S_FAIL = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IW:0]     num_q;
   logic [IW:0]     match_cnt_q;
   logic [7:0]      ignore_cnt_q;
   logic [CW-1:0]   cyc_q;
   logic [1:0]      fail_code_q;
   logic [AW-1:0]   err_adr_q;
   logic [DW-1:0]   err_data_q;
   logic            busy_q, pass_q, fail_q;

   logic [AW-1:0]   mem_adr  [DEPTH];
   logic [DW-1:0]   mem_data [DEPTH];

   // NOTE: the expected-entry table has no reset so it maps onto plain RAM and
   // survives a mid-run reset; contents are only meaningful once loaded.
   always_ff @(posedge clk) begin
      if (exp_we && state_q != S_RUN && int'(exp_idx) < DEPTH) begin
         mem_adr[exp_idx]  <= exp_adr;
         mem_data[exp_idx] <= exp_data;
      end
   end

   logic [IW-1:0] cur_idx;
   logic [IW:0]   match_nxt;
   logic [IW:0]   num_clamped;
   logic          hit, ign, tmo;

   assign cur_idx     = match_cnt_q[IW-1:0];
   assign match_nxt   = match_cnt_q + (IW + 1)'(1);
   assign num_clamped = (num_exp > DEPTH_L) ? DEPTH_L : num_exp;
   assign hit         = (dataadr == mem_adr[cur_idx]) && (writedata == mem_data[cur_idx]);
   assign ign         = IGNORE_EN && (dataadr == IGNORE_ADR);
   assign tmo         = (cyc_q == TMO_LAST);

   logic do_start, inc_match, inc_ign, set_mismatch, set_timeout;

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      do_start     = 1'b0;
      inc_match    = 1'b0;
      inc_ign      = 1'b0;
      set_mismatch = 1'b0;
      set_timeout  = 1'b0;
      case (state_q)
         S_RUN: begin
            if (memwrite && hit) begin
               inc_match = 1'b1;
               if (match_nxt == num_q) begin
                  state_d = S_PASS;
               end else if (tmo) begin
                  state_d     = S_FAIL;
                  set_timeout = 1'b1;
               end
            end else if (memwrite && ign) begin
               inc_ign = 1'b1;
               if (tmo) begin
                  state_d     = S_FAIL;
                  set_timeout = 1'b1;
               end
            end else if (memwrite) begin
               state_d      = S_FAIL;
               set_mismatch = 1'b1;
            end else if (tmo) begin
               state_d     = S_FAIL;
               set_timeout = 1'b1;
            end
         end
         default: begin
            // start from PASS/FAIL behaves as clear followed by start
            if (start) begin
               do_start = 1'b1;
               state_d  = (num_clamped == '0) ? S_PASS : S_RUN;
            end else if (clear && state_q != S_IDLE) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         num_q        <= '0;
         match_cnt_q  <= '0;
         ignore_cnt_q <= '0;
         cyc_q        <= '0;
         fail_code_q  <= 2'd0;
         err_adr_q    <= '0;
         err_data_q   <= '0;
         busy_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == S_RUN);
         pass_q  <= (state_d == S_PASS);
         fail_q  <= (state_d == S_FAIL);
         if (do_start) begin
            num_q        <= num_clamped;
            match_cnt_q  <= '0;
            ignore_cnt_q <= '0;
            cyc_q        <= '0;
            fail_code_q  <= 2'd0;
            err_adr_q    <= '0;
            err_data_q   <= '0;
         end else if (state_q == S_RUN) begin
            cyc_q <= cyc_q + CW'(1);
            if (inc_match) begin
               match_cnt_q <= match_nxt;
            end
            if (inc_ign && ignore_cnt_q != 8'hFF) begin
               ignore_cnt_q <= ignore_cnt_q + 8'd1;
            end
            if (set_mismatch) begin
               fail_code_q <= 2'd1;
               err_adr_q   <= dataadr;
               err_data_q  <= writedata;
            end else if (set_timeout) begin
               fail_code_q <= 2'd2;
               err_adr_q   <= '0;
               err_data_q  <= '0;
            end
         end
      end
   end

   assign busy       = busy_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign fail_code  = fail_code_q;
   assign match_cnt  = match_cnt_q;
   assign ignore_cnt = ignore_cnt_q;
   assign err_adr    = err_adr_q;
   assign err_data   = err_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: ignore path, mismatch, back-to-back,
// timeout boundary, async reset, zero-length run and write protection in RUN.
module tb_mem_write_checker;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int DEPTH = 4;
   localparam int IW = 2;
   localparam int TMO = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          exp_we = 1'b0;
   logic [IW-1:0] exp_idx = '0;
   logic [AW-1:0] exp_adr = '0;
   logic [DW-1:0] exp_data = '0;
   logic [IW:0]   num_exp = '0;
   logic          start = 1'b0;
   logic          clear = 1'b0;
   logic          memwrite = 1'b0;
   logic [AW-1:0] dataadr = '0;
   logic [DW-1:0] writedata = '0;
   logic          busy, pass, fail;
   logic [1:0]    fail_code;
   logic [IW:0]   match_cnt;
   logic [7:0]    ignore_cnt;
   logic [AW-1:0] err_adr;
   logic [DW-1:0] err_data;

   int total = 0;
   int bad = 0;

   mem_write_checker #(
      .DW(DW), .AW(AW), .DEPTH(DEPTH), .IGNORE_EN(1'b1),
      .IGNORE_ADR(32'd80), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .exp_we(exp_we), .exp_idx(exp_idx), .exp_adr(exp_adr), .exp_data(exp_data),
      .num_exp(num_exp), .start(start), .clear(clear),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
      .match_cnt(match_cnt), .ignore_cnt(ignore_cnt),
      .err_adr(err_adr), .err_data(err_data)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load(input logic [IW-1:0] idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_we = 1'b1; exp_idx = idx; exp_adr = a; exp_data = d;
      tick();
      exp_we = 1'b0;
   endtask

   task automatic go(input logic [IW:0] n);
      num_exp = n; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
      memwrite = 1'b1; dataadr = a; writedata = d;
      tick();
      memwrite = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total++; if ({busy, pass, fail} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, pass, fail}); end
      total++; if ({fail_code, match_cnt, ignore_cnt} !== 13'd0) begin bad++; $display("FAIL reset_counts got=%h exp=0", {fail_code, match_cnt, ignore_cnt}); end
      total++; if ({err_adr, err_data} !== 64'd0) begin bad++; $display("FAIL reset_err got=%h exp=0", {err_adr, err_data}); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_ignore();
      load(2'd0, 32'd84, 32'd7);
      go(3'd1);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b exp=1", busy); end
      store(32'd80, 32'd11);
      store(32'd80, 32'd22);
      total++; if ({busy, pass, ignore_cnt} !== {1'b1, 1'b0, 8'd2}) begin bad++; $display("FAIL ign_mid got=%h exp=%h", {busy, pass, ignore_cnt}, {1'b1, 1'b0, 8'd2}); end
      store(32'd84, 32'd7);
      total++; if ({busy, pass, fail} !== 3'b010) begin bad++; $display("FAIL ign_pass got=%b exp=010", {busy, pass, fail}); end
      total++; if (ignore_cnt !== 8'd2) begin bad++; $display("FAIL ign_cnt got=%0d exp=2", ignore_cnt); end
      total++; if ({match_cnt, fail_code} !== {3'd1, 2'd0}) begin bad++; $display("FAIL ign_match got=%h exp=%h", {match_cnt, fail_code}, {3'd1, 2'd0}); end
   endtask

   task automatic test_mismatch();
      go(3'd1);
      store(32'd84, 32'd6);
      total++; if ({fail, fail_code} !== {1'b1, 2'd1}) begin bad++; $display("FAIL mm_data_code got=%h exp=%h", {fail, fail_code}, {1'b1, 2'd1}); end
      total++; if ({err_adr, err_data} !== {32'd84, 32'd6}) begin bad++; $display("FAIL mm_data_err got=%h exp=%h", {err_adr, err_data}, {32'd84, 32'd6}); end
      go(3'd1);
      total++; if ({busy, err_adr, fail_code} !== {1'b1, 32'd0, 2'd0}) begin bad++; $display("FAIL mm_restart got=%h exp=%h", {busy, err_adr, fail_code}, {1'b1, 32'd0, 2'd0}); end
      store(32'd60, 32'd7);
      total++; if ({fail, fail_code, err_adr, err_data} !== {1'b1, 2'd1, 32'd60, 32'd7}) begin bad++; $display("FAIL mm_adr got=%h exp=%h", {fail, fail_code, err_adr, err_data}, {1'b1, 2'd1, 32'd60, 32'd7}); end
   endtask

   task automatic test_back_to_back();
      load(2'd1, 32'd88, 32'd5);
      load(2'd2, 32'd92, 32'hFFFF_FFFF);
      go(3'd3);
      memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7;
      tick();
      dataadr = 32'd88; writedata = 32'd5;
      tick();
      total++; if ({busy, match_cnt} !== {1'b1, 3'd2}) begin bad++; $display("FAIL b2b_mid got=%h exp=%h", {busy, match_cnt}, {1'b1, 3'd2}); end
      dataadr = 32'd92; writedata = 32'hFFFF_FFFF;
      tick();
      memwrite = 1'b0;
      total++; if ({pass, fail, match_cnt} !== {1'b1, 1'b0, 3'd3}) begin bad++; $display("FAIL b2b_pass got=%h exp=%h", {pass, fail, match_cnt}, {1'b1, 1'b0, 3'd3}); end
      go(3'd3);
      store(32'd88, 32'd5);
      total++; if ({fail, fail_code, err_adr, match_cnt} !== {1'b1, 2'd1, 32'd88, 3'd0}) begin bad++; $display("FAIL b2b_order got=%h exp=%h", {fail, fail_code, err_adr, match_cnt}, {1'b1, 2'd1, 32'd88, 3'd0}); end
      // num_exp above DEPTH clamps to 4 entries
      load(2'd3, 32'd96, 32'd1);
      go(3'd7);
      store(32'd84, 32'd7);
      store(32'd88, 32'd5);
      store(32'd92, 32'hFFFF_FFFF);
      total++; if ({busy, match_cnt} !== {1'b1, 3'd3}) begin bad++; $display("FAIL clamp_mid got=%h exp=%h", {busy, match_cnt}, {1'b1, 3'd3}); end
      store(32'd96, 32'd1);
      total++; if ({pass, match_cnt} !== {1'b1, 3'd4}) begin bad++; $display("FAIL clamp_pass got=%h exp=%h", {pass, match_cnt}, {1'b1, 3'd4}); end
   endtask

   task automatic test_timeout();
      go(3'd1);
      ticks(TMO - 1);
      total++; if ({busy, fail} !== 2'b10) begin bad++; $display("FAIL tmo_early got=%b exp=10", {busy, fail}); end
      tick();
      total++; if ({fail, fail_code, err_adr, err_data} !== {1'b1, 2'd2, 64'd0}) begin bad++; $display("FAIL tmo_fire got=%h exp=%h", {fail, fail_code, err_adr, err_data}, {1'b1, 2'd2, 64'd0}); end
      go(3'd1);
      ticks(TMO - 1);
      store(32'd84, 32'd7);
      total++; if ({pass, fail, fail_code} !== {1'b1, 1'b0, 2'd0}) begin bad++; $display("FAIL tmo_match got=%h exp=%h", {pass, fail, fail_code}, {1'b1, 1'b0, 2'd0}); end
      go(3'd1);
      ticks(TMO - 1);
      store(32'd70, 32'd3);
      total++; if ({fail, fail_code, err_adr} !== {1'b1, 2'd1, 32'd70}) begin bad++; $display("FAIL tmo_mm_prio got=%h exp=%h", {fail, fail_code, err_adr}, {1'b1, 2'd1, 32'd70}); end
   endtask

   task automatic test_async_reset();
      go(3'd2);
      store(32'd80, 32'd9);
      store(32'd84, 32'd7);
      total++; if ({busy, match_cnt, ignore_cnt} !== {1'b1, 3'd1, 8'd1}) begin bad++; $display("FAIL ar_before got=%h exp=%h", {busy, match_cnt, ignore_cnt}, {1'b1, 3'd1, 8'd1}); end
      #2 rst = 1'b0;
      #1;
      total++; if ({busy, pass, fail, fail_code, match_cnt, ignore_cnt} !== 16'd0) begin bad++; $display("FAIL ar_async got=%h exp=0", {busy, pass, fail, fail_code, match_cnt, ignore_cnt}); end
      #1 rst = 1'b1;
      tick();
      total++; if ({busy, pass, fail} !== 3'b000) begin bad++; $display("FAIL ar_idle got=%b exp=000", {busy, pass, fail}); end
      go(3'd2);
      store(32'd84, 32'd7);
      store(32'd88, 32'd5);
      total++; if ({pass, match_cnt} !== {1'b1, 3'd2}) begin bad++; $display("FAIL ar_rerun got=%h exp=%h", {pass, match_cnt}, {1'b1, 3'd2}); end
   endtask

   task automatic test_zero_and_we();
      go(3'd0);
      total++; if ({busy, pass, match_cnt} !== {1'b0, 1'b1, 3'd0}) begin bad++; $display("FAIL zero_pass got=%h exp=%h", {busy, pass, match_cnt}, {1'b0, 1'b1, 3'd0}); end
      go(3'd1);
      load(2'd0, 32'd84, 32'd9);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL we_run_busy got=%b exp=1", busy); end
      store(32'd84, 32'd7);
      total++; if ({pass, fail} !== 2'b10) begin bad++; $display("FAIL we_run_same got=%b exp=10", {pass, fail}); end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      total++; if ({busy, pass, fail, match_cnt} !== {3'b000, 3'd1}) begin bad++; $display("FAIL clear_hold got=%h exp=%h", {busy, pass, fail, match_cnt}, {3'b000, 3'd1}); end
      go(3'd1);
      store(32'd84, 32'd7);
      total++; if ({pass, fail, fail_code} !== {1'b1, 1'b0, 2'd0}) begin bad++; $display("FAIL we_later_run got=%h exp=%h", {pass, fail, fail_code}, {1'b1, 1'b0, 2'd0}); end
   endtask

   initial begin
      test_reset();
      test_ignore();
      test_mismatch();
      test_back_to_back();
      test_timeout();
      test_async_reset();
      test_zero_and_we();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
